ram_nr1w: RTL and testbench

Parametrised unified memory model: NRD independent read ports and one byte-masked write port share one on-chip storage array mapped at a configurable base address. It replaces the older two-read/one-write DPI-backed memory with synthesizable storage, a registered read path and per-port valid/ready handshakes, so core fetch, load/store and additional requestors can stall and be back-pressured. It sits between the core's memory-access units and the simulation top level.

---
 rtl/ram_nr1w.sv | 121 ++++++++++++
 tb/tb_ram_nr1w.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_nr1w.sv
// ram_nr1w: NRD-read / 1-write unified memory with a registered read path.
// Ports: clk, rst_n, rd_req_*/rd_resp_*/rd_addr/rd_rdata/rd_err per read port;
//   wr_en/wr_addr/wr_wdata/wr_strb write port; wr_err flags a dropped write.
// Optional: RAM_NR1W_BYPASS_EN selects write-before-read on same-index collision.
module ram_nr1w #(
  parameter int DATA_W = 64,
  parameter int DEPTH = 1024,
  parameter int NRD = 2,
  parameter int ADDR_W = 64,
  parameter logic [ADDR_W-1:0] BASE = 64'h0000_0000_8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD-1:0]        rd_req_valid,
  output logic [NRD-1:0]        rd_req_ready,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD-1:0]        rd_resp_valid,
  input  logic [NRD-1:0]        rd_resp_ready,
  output logic [NRD*DATA_W-1:0] rd_rdata,
  output logic [NRD-1:0]        rd_err,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_wdata,
  input  logic [DATA_W/8-1:0]   wr_strb,
  output logic                  wr_err
);

  localparam int NB = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LIMIT =
    ADDR_W'(DEPTH * NB);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_off;
  logic              wr_ok;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_do;

  assign wr_off = wr_addr - BASE;
  assign wr_ok  = (wr_addr >= BASE) && (wr_off < LIMIT);
  assign wr_idx = wr_off[OFF_W +: IDX_W];
  assign wr_do  = wr_en & wr_ok;

  // Storage is never cleared; the reset branch is empty so a write
  // is only taken on an edge where rst_n is already high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (wr_do) begin
      for (int k = 0; k < NB; k++) begin
        if (wr_strb[k]) begin
          mem[wr_idx][8*k +: 8] <= wr_wdata[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en & ~wr_ok;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] off;
    logic              ok;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] word;
    logic              acc;
    logic              vld_q;
    logic              err_q;
    logic [DATA_W-1:0] dat_q;

    assign addr = rd_addr[i*ADDR_W +: ADDR_W];
    assign off  = addr - BASE;
    assign ok   = (addr >= BASE) && (off < LIMIT);
    assign idx  = off[OFF_W +: IDX_W];

    assign rd_req_ready[i] = ~vld_q | rd_resp_ready[i];
    assign acc = rd_req_valid[i] & rd_req_ready[i];

`ifdef RAM_NR1W_BYPASS_EN
    // Merge the in-flight write so the read sees post-write bytes.
    always_comb begin
      word = mem[idx];
      if (wr_do && (wr_idx == idx)) begin
        for (int k = 0; k < NB; k++) begin
          if (wr_strb[k]) begin
            word[8*k +: 8] = wr_wdata[8*k +: 8];
          end
        end
      end
    end
`else
    assign word = mem[idx];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        err_q <= 1'b0;
        dat_q <= '0;
      end else if (acc) begin
        vld_q <= 1'b1;
        err_q <= ~ok;
        dat_q <= ok ? word : '0;
      end else if (rd_resp_ready[i]) begin
        vld_q <= 1'b0;
      end
    end

    assign rd_resp_valid[i] = vld_q;
    assign rd_err[i] = err_q;
    assign rd_rdata[i*DATA_W +: DATA_W] = dat_q;
  end

endmodule

// File: tb/tb_ram_nr1w.sv
// tb_ram_nr1w: directed self-checking bench for ram_nr1w.
// Default parameters: 64-bit words, 1024 deep, 2 read ports.
module tb_ram_nr1w;

  localparam logic [63:0] B = 64'h0000_0000_8000_0000;

  logic         clk;
  logic         rst_n;
  logic [1:0]   rd_req_valid;
  logic [1:0]   rd_req_ready;
  logic [127:0] rd_addr;
  logic [1:0]   rd_resp_valid;
  logic [1:0]   rd_resp_ready;
  logic [127:0] rd_rdata;
  logic [1:0]   rd_err;
  logic         wr_en;
  logic [63:0]  wr_addr;
  logic [63:0]  wr_wdata;
  logic [7:0]   wr_strb;
  logic         wr_err;

  int total;
  int bad;

  ram_nr1w dut (
    .clk(clk),
    .rst_n(rst_n),
    .rd_req_valid(rd_req_valid),
    .rd_req_ready(rd_req_ready),
    .rd_addr(rd_addr),
    .rd_resp_valid(rd_resp_valid),
    .rd_resp_ready(rd_resp_ready),
    .rd_rdata(rd_rdata),
    .rd_err(rd_err),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_wdata(wr_wdata),
    .wr_strb(wr_strb),
    .wr_err(wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [63:0] a,
                    input logic [63:0] d,
                    input logic [7:0] s);
    wr_en = 1'b1;
    wr_addr = a;
    wr_wdata = d;
    wr_strb = s;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (rd_resp_valid !== 2'b00) begin
      bad++;
      $display("FAIL rst_valid got=%b want=00", rd_resp_valid);
    end
    total++;
    if (rd_rdata !== 128'h0) begin
      bad++;
      $display("FAIL rst_rdata got=%h want=0", rd_rdata);
    end
    total++;
    if (rd_err !== 2'b00 || wr_err !== 1'b0) begin
      bad++;
      $display("FAIL rst_err got=%b/%b want=00/0", rd_err, wr_err);
    end
    total++;
    if (rd_req_ready !== 2'b11) begin
      bad++;
      $display("FAIL rst_ready got=%b want=11", rd_req_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    wr(B + 64'h8, 64'h1122334455667788, 8'hFF);
    total++;
    if (wr_err !== 1'b0) begin
      bad++;
      $display("FAIL wr_ok_err got=%b want=0", wr_err);
    end
    rd_resp_ready = 2'b11;
    rd_req_valid = 2'b01;
    rd_addr[63:0] = B + 64'hC;
    tick();
    rd_req_valid = 2'b00;
    total++;
    if (rd_resp_valid[0] !== 1'b1 || rd_err[0] !== 1'b0 ||
        rd_rdata[63:0] !== 64'h1122334455667788) begin
      bad++;
      $display("FAIL full_read got=%b/%b/%h want=1/0/1122334455667788",
               rd_resp_valid[0], rd_err[0], rd_rdata[63:0]);
    end
    tick();
    total++;
    if (rd_resp_valid[0] !== 1'b0) begin
      bad++;
      $display("FAIL consume got=%b want=0", rd_resp_valid[0]);
    end
  endtask

  task automatic test_partial();
    wr(B + 64'h8, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    wr(B + 64'h8, 64'h5555555555555555, 8'h00);
    rd_req_valid = 2'b01;
    rd_addr[63:0] = B + 64'h8;
    tick();
    rd_req_valid = 2'b00;
    total++;
    if (rd_rdata[63:0] !== 64'h11223344AAAAAAAA) begin
      bad++;
      $display("FAIL partial got=%h want=11223344aaaaaaaa",
               rd_rdata[63:0]);
    end
    tick();
  endtask

  task automatic test_range();
    wr(B, 64'h0123456789ABCDEF, 8'hFF);
    rd_req_valid = 2'b11;
    rd_addr[63:0] = B + 64'h8;
    rd_addr[127:64] = 64'h0000_0000_7FFF_FFF8;
    tick();
    rd_req_valid = 2'b00;
    total++;
    if (rd_rdata[63:0] !== 64'h11223344AAAAAAAA || rd_err[0] !== 1'b0) begin
      bad++;
      $display("FAIL dual_p0 got=%h/%b want=11223344aaaaaaaa/0",
               rd_rdata[63:0], rd_err[0]);
    end
    total++;
    if (rd_resp_valid[1] !== 1'b1 || rd_err[1] !== 1'b1 ||
        rd_rdata[127:64] !== 64'h0) begin
      bad++;
      $display("FAIL low_oor got=%b/%b/%h want=1/1/0",
               rd_resp_valid[1], rd_err[1], rd_rdata[127:64]);
    end
    wr(B + 64'h2000, 64'hDEADBEEFDEADBEEF, 8'hFF);
    total++;
    if (wr_err !== 1'b1) begin
      bad++;
      $display("FAIL wr_oor_err got=%b want=1", wr_err);
    end
    tick();
    total++;
    if (wr_err !== 1'b0) begin
      bad++;
      $display("FAIL wr_err_clr got=%b want=0", wr_err);
    end
    rd_req_valid = 2'b11;
    rd_addr[63:0] = B;
    rd_addr[127:64] = B + 64'h2000;
    tick();
    rd_req_valid = 2'b00;
    total++;
    if (rd_rdata[63:0] !== 64'h0123456789ABCDEF) begin
      bad++;
      $display("FAIL oor_no_alias got=%h want=0123456789abcdef",
               rd_rdata[63:0]);
    end
    total++;
    if (rd_err[1] !== 1'b1 || rd_rdata[127:64] !== 64'h0) begin
      bad++;
      $display("FAIL high_oor got=%b/%h want=1/0",
               rd_err[1], rd_rdata[127:64]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    wr(B + 64'h10, 64'h2222222222222222, 8'hFF);
    wr(B + 64'h18, 64'h3333333333333333, 8'hFF);
    rd_resp_ready = 2'b00;
    rd_req_valid = 2'b01;
    rd_addr[63:0] = B + 64'h10;
    tick();
    rd_addr[63:0] = B + 64'h18;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (rd_req_ready[0] !== 1'b0 || rd_resp_valid[0] !== 1'b1 ||
          rd_rdata[63:0] !== 64'h2222222222222222) begin
        bad++;
        $display("FAIL stall%0d got=%b/%b/%h want=0/1/2222222222222222",
                 c, rd_req_ready[0], rd_resp_valid[0], rd_rdata[63:0]);
      end
      tick();
    end
    rd_resp_ready = 2'b11;
    #1;
    total++;
    if (rd_req_ready[0] !== 1'b1) begin
      bad++;
      $display("FAIL release_ready got=%b want=1", rd_req_ready[0]);
    end
    tick();
    rd_addr[63:0] = B + 64'h8;
    total++;
    if (rd_resp_valid[0] !== 1'b1 ||
        rd_rdata[63:0] !== 64'h3333333333333333) begin
      bad++;
      $display("FAIL b2b_1 got=%b/%h want=1/3333333333333333",
               rd_resp_valid[0], rd_rdata[63:0]);
    end
    tick();
    rd_req_valid = 2'b00;
    total++;
    if (rd_resp_valid[0] !== 1'b1 ||
        rd_rdata[63:0] !== 64'h11223344AAAAAAAA) begin
      bad++;
      $display("FAIL b2b_2 got=%b/%h want=1/11223344aaaaaaaa",
               rd_resp_valid[0], rd_rdata[63:0]);
    end
    tick();
    total++;
    if (rd_resp_valid[0] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain got=%b want=0", rd_resp_valid[0]);
    end
  endtask

  task automatic test_same_cycle();
    logic [63:0] exp;
`ifdef RAM_NR1W_BYPASS_EN
    exp = 64'hFFFFFFFFFFFFFFFF;
`else
    exp = 64'h0;
`endif
    wr(B + 64'h20, 64'h0, 8'hFF);
    rd_req_valid = 2'b01;
    rd_addr[63:0] = B + 64'h20;
    wr(B + 64'h20, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    total++;
    if (rd_rdata[63:0] !== exp) begin
      bad++;
      $display("FAIL collide got=%h want=%h", rd_rdata[63:0], exp);
    end
    tick();
    rd_req_valid = 2'b00;
    total++;
    if (rd_rdata[63:0] !== 64'hFFFFFFFFFFFFFFFF) begin
      bad++;
      $display("FAIL collide_commit got=%h want=ffffffffffffffff",
               rd_rdata[63:0]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    rd_resp_ready = 2'b00;
    rd_req_valid = 2'b11;
    rd_addr[63:0] = B + 64'h8;
    rd_addr[127:64] = B + 64'h10;
    tick();
    rd_req_valid = 2'b00;
    total++;
    if (rd_resp_valid !== 2'b11) begin
      bad++;
      $display("FAIL pend got=%b want=11", rd_resp_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (rd_resp_valid !== 2'b00 || rd_rdata !== 128'h0 ||
        rd_req_ready !== 2'b11) begin
      bad++;
      $display("FAIL async_rst got=%b/%h/%b want=00/0/11",
               rd_resp_valid, rd_rdata, rd_req_ready);
    end
    wr(B + 64'h8, 64'h0, 8'hFF);
    rst_n = 1'b1;
    rd_resp_ready = 2'b11;
    rd_req_valid = 2'b10;
    rd_addr[127:64] = B + 64'h8;
    tick();
    rd_req_valid = 2'b00;
    total++;
    if (rd_resp_valid[1] !== 1'b1 ||
        rd_rdata[127:64] !== 64'h11223344AAAAAAAA) begin
      bad++;
      $display("FAIL retain got=%b/%h want=1/11223344aaaaaaaa",
               rd_resp_valid[1], rd_rdata[127:64]);
    end
    tick();
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    rd_req_valid = '0;
    rd_addr = '0;
    rd_resp_ready = '0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_wdata = '0;
    wr_strb = '0;
    tick();
    test_reset();
    test_write_read();
    test_partial();
    test_range();
    test_back_to_back();
    test_same_cycle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
